mycpu_mem_access_unit: RTL

//  Parametrised MEM-stage load/store unit with a one-outstanding-access valid/ready handshake.

---
 rtl/mycpu_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mycpu_mem_access_unit.sv
// mycpu_mem_access_unit
//   MEM-stage load/store unit with one outstanding access and valid/ready
//   handshakes on both the request and the response side. Drives a data SRAM
//   with a fixed one-cycle read latency. Stores get byte enables and
//   lane-shifted write data. Loads are aligned and then sign- or zero-extended.
//   Misaligned accesses and reserved ops are reported instead of issued.
//
//   Optional feature: define MEM_UNALIGNED_LR_EN to support LWL/LWR/SWL/SWR.
//   Without it, those four ops are reserved and the merge logic is not built.
module mycpu_mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_rt,
  input  logic [4:0]          req_dest,
  output logic                data_sram_en,
  output logic [DATA_W/8-1:0] data_sram_wen,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [4:0]          rsp_dest,
  output logic                rsp_wb,
  output logic                rsp_adel,
  output logic                rsp_ades,
  output logic                rsp_ri
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [NB-1:0]     mask_t;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,  OP_LBU = 4'd1,  OP_LH  = 4'd2,  OP_LHU = 4'd3,
    OP_LW  = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6,  OP_LD  = 4'd7,
    OP_SB  = 4'd8,  OP_SH  = 4'd9,  OP_SW  = 4'd10, OP_SWL = 4'd11,
    OP_SWR = 4'd12, OP_SD  = 4'd13
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_RSP} state_e;

  // State
  state_e        r_state;
  op_e           r_op;
  logic [LB-1:0] r_k;
  logic          r_rsp_valid;
  data_t         r_rsp_data;
  logic [4:0]    r_rsp_dest;
  logic          r_rsp_wb;
  logic          r_rsp_adel;
  logic          r_rsp_ades;
  logic          r_rsp_ri;
`ifdef MEM_UNALIGNED_LR_EN
  logic [31:0]   r_rt;
`endif

  // Request-side decode
  logic          w_accept;
  logic          w_go;
  logic          w_is_load;
  logic          w_ri;
  logic          w_mis;
  logic [LB-1:0] w_k;
  mask_t         w_mask;
  data_t         w_wdata;
`ifdef MEM_UNALIGNED_LR_EN
  logic [1:0]    w_o;
  logic          w_h;
  logic          w_lr_store;
  logic [3:0]    w_lr_mask4;
  logic [31:0]   w_lr_data32;
`endif

  // Load formatting
  data_t         w_rshift;
  data_t         w_load;
`ifdef MEM_UNALIGNED_LR_EN
  logic [1:0]    w_ro;
  logic          w_rh;
  data_t         w_rword_all;
  logic [31:0]   w_rword;
  logic [31:0]   w_lwl;
  logic [31:0]   w_lwr;
`endif

  assign w_k       = req_addr[LB-1:0];
  assign w_is_load = ~req_op[3];
  assign req_ready = (r_state == S_IDLE) | ((r_state == S_RSP) & rsp_ready);
  assign w_accept  = req_valid & req_ready;
  assign w_go      = w_accept & ~w_ri & ~w_mis;

`ifdef MEM_UNALIGNED_LR_EN
  assign w_o = req_addr[1:0];
  assign w_h = (NB == 8) ? req_addr[LB-1] : 1'b0;
`endif

  // Classify the request and build the store lane pattern.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    w_ri    = 1'b0;
    w_mis   = 1'b0;
    w_mask  = '0;
    w_wdata = '0;
`ifdef MEM_UNALIGNED_LR_EN
    w_lr_store  = 1'b0;
    w_lr_mask4  = 4'b0000;
    w_lr_data32 = 32'h0;
`endif
    case (req_op)
      OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: w_mis = req_addr[0];
      OP_LW:         w_mis = |req_addr[1:0];
      OP_LD: begin
        if (DATA_W == 32) w_ri  = 1'b1;
        else              w_mis = |req_addr[2:0];
      end
      OP_SB: begin
        w_mask  = mask_t'(1) << w_k;
        w_wdata = req_rt << {w_k, 3'b000};
      end
      OP_SH: begin
        w_mis   = req_addr[0];
        w_mask  = mask_t'(2'b11) << w_k;
        w_wdata = req_rt << {w_k, 3'b000};
      end
      OP_SW: begin
        w_mis   = |req_addr[1:0];
        w_mask  = mask_t'(4'hF) << w_k;
        w_wdata = req_rt << {w_k, 3'b000};
      end
      OP_SD: begin
        if (DATA_W == 32) w_ri = 1'b1;
        else              w_mis = |req_addr[2:0];
        w_mask  = '1;
        w_wdata = req_rt;
      end
`ifdef MEM_UNALIGNED_LR_EN
      OP_LWL, OP_LWR: ;
      OP_SWL: begin
        // Low lanes receive the top (o+1) bytes of rt.
        w_lr_store  = 1'b1;
        w_lr_mask4  = 4'b1111 >> ~w_o;
        w_lr_data32 = req_rt[31:0] >> {~w_o, 3'b000};
      end
      OP_SWR: begin
        // Lanes o..3 receive the bottom (4-o) bytes of rt.
        w_lr_store  = 1'b1;
        w_lr_mask4  = 4'b1111 << w_o;
        w_lr_data32 = req_rt[31:0] << {w_o, 3'b000};
      end
`else
      OP_LWL, OP_LWR, OP_SWL, OP_SWR: w_ri = 1'b1;
`endif
      default: w_ri = 1'b1;
    endcase
`ifdef MEM_UNALIGNED_LR_EN
    // Place the 4-lane word pattern in the addressed half of a 64-bit line.
    if (w_lr_store) begin
      w_mask  = mask_t'(w_lr_mask4) << {w_h, 2'b00};
      w_wdata = data_t'(w_lr_data32) << {w_h, 5'b00000};
    end
`endif
  end

  // SRAM is driven only in the accept cycle of a legal access.
  assign data_sram_en    = w_go;
  assign data_sram_wen   = w_go ? w_mask : '0;
  assign data_sram_addr  = w_go ? {req_addr[ADDR_W-1:LB], {LB{1'b0}}} : '0;
  assign data_sram_wdata = w_go ? w_wdata : '0;

`ifdef MEM_UNALIGNED_LR_EN
  assign w_ro        = r_k[1:0];
  assign w_rh        = (NB == 8) ? r_k[LB-1] : 1'b0;
  assign w_rword_all = data_sram_rdata >> {w_rh, 5'b00000};
  assign w_rword     = w_rword_all[31:0];
  assign w_lwl = (w_rword << {~w_ro, 3'b000}) | (r_rt & (32'h00FF_FFFF >> {w_ro, 3'b000}));
  assign w_lwr = (w_rword >> {w_ro, 3'b000}) | (r_rt & ~(32'hFFFF_FFFF >> {w_ro, 3'b000}));
`endif

  // Align the returned SRAM word to lane 0 and extend it per the latched op.
  always_comb begin
    w_rshift = data_sram_rdata >> {r_k, 3'b000};
    w_load   = '0;
    case (r_op)
      OP_LB:  w_load = data_t'($signed(w_rshift[7:0]));
      OP_LBU: w_load = data_t'(w_rshift[7:0]);
      OP_LH:  w_load = data_t'($signed(w_rshift[15:0]));
      OP_LHU: w_load = data_t'(w_rshift[15:0]);
      OP_LW:  w_load = data_t'($signed(w_rshift[31:0]));
      OP_LD:  w_load = data_sram_rdata;
`ifdef MEM_UNALIGNED_LR_EN
      OP_LWL: w_load = data_t'($signed(w_lwl));
      OP_LWR: w_load = data_t'($signed(w_lwr));
`endif
      default: w_load = '0;
    endcase
  end

  // Access FSM: accept, wait out the SRAM read, hold the response until taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: only control and output registers exist here and all are reset,
      // so an access in flight is simply dropped and late rdata is ignored.
      r_state     <= S_IDLE;
      r_op        <= OP_LB;
      r_k         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_dest  <= '0;
      r_rsp_wb    <= 1'b0;
      r_rsp_adel  <= 1'b0;
      r_rsp_ades  <= 1'b0;
      r_rsp_ri    <= 1'b0;
`ifdef MEM_UNALIGNED_LR_EN
      r_rt        <= '0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      case (r_state)
        S_RD: begin
          r_state     <= S_RSP;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_load;
          r_rsp_wb    <= 1'b1;
        end
        default: begin
          // IDLE always, RSP only once the consumer takes the response.
          if (req_ready) begin
            if (req_valid) begin
              r_rsp_dest <= req_dest;
              r_rsp_data <= '0;
              r_rsp_wb   <= 1'b0;
              r_rsp_ri   <= w_ri;
              r_rsp_adel <= w_is_load & w_mis & ~w_ri;
              r_rsp_ades <= ~w_is_load & w_mis & ~w_ri;
              if (w_go && w_is_load) begin
                r_state     <= S_RD;
                r_rsp_valid <= 1'b0;
                r_op        <= op_e'(req_op);
                r_k         <= w_k;
`ifdef MEM_UNALIGNED_LR_EN
                r_rt        <= req_rt[31:0];
`endif
              end else begin
                r_state     <= S_RSP;
                r_rsp_valid <= 1'b1;
              end
            end else begin
              r_state     <= S_IDLE;
              r_rsp_valid <= 1'b0;
              r_rsp_data  <= '0;
              r_rsp_wb    <= 1'b0;
              r_rsp_adel  <= 1'b0;
              r_rsp_ades  <= 1'b0;
              r_rsp_ri    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_dest  = r_rsp_dest;
  assign rsp_wb    = r_rsp_wb;
  assign rsp_adel  = r_rsp_adel;
  assign rsp_ades  = r_rsp_ades;
  assign rsp_ri    = r_rsp_ri;

endmodule
